// File: rtl/inst_queue.sv
// inst_queue: compacting 4-in / 2-out instruction queue between fetch and decode
// Ports:
//   clock, reset_n               clock; asynchronous active-low reset
//   in_word*/in_pc*/in_valid*    fetched line, lane 0 lowest address, valid lanes form a suffix
//   in_stream                    stream tag of the fetched line
//   flush                        redirect accepted: empties the queue and flips the expected stream
//   fetch_stall                  queue cannot take a full 4-word line
//   deq_stall                    decode not accepting this cycle
//   out_inst*/out_pc*/out_valid* head and head+1 instructions, zero when invalid
//   count                        occupied entries
module inst_queue #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      in_word0,
  input  logic [31:0]      in_word1,
  input  logic [31:0]      in_word2,
  input  logic [31:0]      in_word3,
  input  logic             in_valid0,
  input  logic             in_valid1,
  input  logic             in_valid2,
  input  logic             in_valid3,
  input  logic [31:0]      in_pc0,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_pc2,
  input  logic [31:0]      in_pc3,
  input  logic             in_stream,
  input  logic             flush,
  output logic             fetch_stall,
  input  logic             deq_stall,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_pc1,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic [PTR_W:0]   count
);
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1;
  logic [PTR_W:0]   count_q, count_d;
  logic             stream_q, stream_d;
  logic [31:0]      word_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [3:0]       lane_v;
  logic [31:0]      lane_w [4];
  logic [31:0]      lane_pc [4];
  logic [2:0]       off [4];
  logic [2:0]       n_enq;
  logic [1:0]       n_deq;
  logic             enq;

  assign lane_v = {in_valid3, in_valid2, in_valid1, in_valid0};

  always_comb begin
    lane_w[0]  = in_word0;
    lane_w[1]  = in_word1;
    lane_w[2]  = in_word2;
    lane_w[3]  = in_word3;
    lane_pc[0] = in_pc0;
    lane_pc[1] = in_pc1;
    lane_pc[2] = in_pc2;
    lane_pc[3] = in_pc3;
  end

  // Each valid lane lands at tail plus the number of valid lanes below it,
  // which compacts the line without relying on the suffix shape.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < 4; i++) begin
      off[i] = n_enq;
      n_enq  = n_enq + {2'b0, lane_v[i]};
    end
  end

  // Stall depends only on registered occupancy so fetch sees a clean timing path.
  assign fetch_stall = count_q > (PTR_W+1)'(DEPTH - 4);
  assign enq         = ~fetch_stall & ~flush & (in_stream == stream_q);

  always_comb begin
    n_deq    = (deq_stall | flush) ? 2'd0 : (count_q > 1 ? 2'd2 : count_q[1:0]);
    head_d   = flush ? '0 : head_q + PTR_W'(n_deq);
    tail_d   = flush ? '0 : tail_q + (enq ? PTR_W'(n_enq) : '0);
    count_d  = flush ? '0 : count_q + (enq ? (PTR_W+1)'(n_enq) : '0) - (PTR_W+1)'(n_deq);
    stream_d = stream_q ^ flush;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      stream_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      stream_q <= stream_d;
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge clock) begin
    if (enq)
      for (int i = 0; i < 4; i++)
        if (lane_v[i]) begin
          word_q[tail_q + PTR_W'(off[i])] <= lane_w[i];
          pc_q[tail_q + PTR_W'(off[i])]   <= lane_pc[i];
        end
  end

  assign head1      = head_q + PTR_W'(1);
  assign out_valid0 = count_q != '0;
  assign out_valid1 = count_q > 1;
  assign out_inst0  = out_valid0 ? word_q[head_q] : '0;
  assign out_pc0    = out_valid0 ? pc_q[head_q] : '0;
  assign out_inst1  = out_valid1 ? word_q[head1] : '0;
  assign out_pc1    = out_valid1 ? pc_q[head1] : '0;
  assign count      = count_q;
endmodule
